fb_write_scheduler: RTL and testbench
=====================================

Name: fb_write_scheduler

Overview:
- Sole owner of the 160x120, 3-bit framebuffer write port: drives mem_we, mem_addr and mem_data into the video memory.
- Serves two requesters:
  - a single-pixel draw port with a valid/ready handshake;
  - an internal rectangle-fill engine (clear screen, solid boxes).
- When both requesters contend, grants alternate round-robin. At most one write per clock.

Parameters:
- H_RES, 160, pixels per line; row stride of the linear address.
- V_RES, 120, lines per frame.
- ADDR_W, 16, width of mem_addr; must hold H_RES*V_RES-1.
- DATA_W, 3, pixel colour width.

Ports:
- clk_write  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- pix_valid  in  1  pixel write request.
- pix_ready  out  1  pixel accepted on this edge when pix_valid & pix_ready.
- pix_x  in  8  pixel column.
- pix_y  in  7  pixel row.
- pix_color  in  DATA_W  pixel colour.
- fill_start  in  1  one-cycle pulse; starts a fill, ignored while fill_busy.
- fill_x0  in  8  fill left column.
- fill_x1  in  8  fill right column, inclusive.
- fill_y0  in  7  fill top row.
- fill_y1  in  7  fill bottom row, inclusive.
- fill_color  in  DATA_W  fill colour.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when a fill completes.
- fill_error  out  1  one-cycle pulse when a fill command is rejected.
- mem_we  out  1  framebuffer write enable (registered).
- mem_addr  out  ADDR_W  linear address y*H_RES+x (registered).
- mem_data  out  DATA_W  write data (registered).

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=0, mem_data=0.
  - fill_busy=0, fill_done=0, fill_error=0.
  - FSM=IDLE, round-robin pointer = pixel-first.
  - Reset mid-fill aborts the fill with no fill_done.
- FSM states IDLE, FILL.
- IDLE:
  - fill_start is sampled with its coordinates.
  - Command is valid iff x0<=x1, y0<=y1, x1<H_RES and y1<V_RES.
  - Valid command: latch coords and colour, cur_x=x0, cur_y=y0, row_base=y0*H_RES. Go to FILL next cycle; fill_busy=1 from that cycle.
  - Invalid command: fill_error=1 for one cycle, stay IDLE, no writes.
- FILL:
  - The engine presents one beat per cycle at address row_base+cur_x.
  - On a grant: if cur_x==x1, then cur_x=x0, cur_y++ and row_base+=H_RES; otherwise cur_x++.
  - No multiplier is used in the scan loop.
  - Granting the beat at (x1,y1) returns the FSM to IDLE.
  - fill_busy=0 and fill_done=1 in the following cycle, which is the same cycle the last mem_we is visible.
  - fill_start during FILL is ignored: no error, no restart.
- Arbitration, evaluated each cycle:
  - Only pixel requesting: pixel granted.
  - Only fill requesting: fill granted.
  - Both requesting: the requester not granted last time wins. The pointer updates only on contended grants.
  - pix_ready is combinational: 1 unless the FSM is in FILL and the pointer favours fill. pix_ready is independent of pix_valid.
- Pixel path:
  - An accepted pixel with pix_x<H_RES and pix_y<V_RES produces mem_we=1, mem_addr=pix_y*H_RES+pix_x, mem_data=pix_color in the next cycle.
  - Out-of-range pixels are accepted (handshake completes) and dropped: no write.
- Latency: grant at edge N gives mem_we high during cycle N+1. A cycle with no grant gives mem_we=0; mem_addr and mem_data hold their last values.
- Throughput:
  - Uncontended fill of W x H: W*H consecutive write cycles, first mem_we two cycles after the fill_start edge.
  - Under continuous pixel traffic, each requester gets 50% of slots.
- Width rules: the address is computed at ADDR_W bits; no overflow is possible for legal coordinates.

Test Plan:
- Pixel write (5,2), colour 3 in IDLE -> accepted the same cycle; next cycle mem_we=1, mem_addr=325, mem_data=3; the following cycle mem_we=0.
- Full clear (0,0)-(159,119), colour 0, no pixel traffic -> 19200 consecutive writes at addr 0..19199 in order; fill_done pulses with the write to 19199; fill_busy low afterwards.
- Fill (10,10)-(13,10), colour 5, with pix_valid held high (pixel (0,0), colour 1) -> mem_we stream alternates pixel/fill; fill addresses 1610..1613 complete within 8 write cycles; no pixel write is lost or duplicated.
- Invalid fill x0=20, x1=10 -> fill_error pulses one cycle, fill_busy stays 0, no mem_we. Also fill_start during an active fill -> ignored, original fill completes unchanged.
- Out-of-range pixel (160,0) -> handshake completes, mem_we stays 0.
- Assert reset mid-fill -> all outputs 0 immediately (asynchronous); after release, no fill_done; FSM returns to IDLE and accepts a new fill.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: sole writer of the 160x120 framebuffer, arbitrating single-pixel
// draws against a rectangle-fill engine with round-robin grants under contention.
module fb_write_scheduler #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 3
) (
    input  logic              clk_write,
    input  logic              reset,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_x,
    input  logic [6:0]        pix_y,
    input  logic [DATA_W-1:0] pix_color,
    input  logic              fill_start,
    input  logic [7:0]        fill_x0,
    input  logic [7:0]        fill_x1,
    input  logic [6:0]        fill_y0,
    input  logic [6:0]        fill_y1,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_error,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data
);
    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] V_A = ADDR_W'(V_RES);

    state_t            state_q, state_d;
    logic              fav_fill_q, fav_fill_d;
    logic [7:0]        x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
    logic [6:0]        y1_q, y1_d, cur_y_q, cur_y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              fill_done_q, fill_done_d, fill_error_q, fill_error_d;

    logic              fill_req, pix_grant, fill_grant, pix_in, cmd_ok, last_beat, pix_wr;
    logic [ADDR_W-1:0] pix_addr, fill_addr;

    assign fill_req   = state_q == FILL;
    assign pix_ready  = !(fill_req && fav_fill_q);
    assign pix_grant  = pix_valid && pix_ready;
    assign fill_grant = fill_req && !pix_grant;
    assign pix_in     = ADDR_W'(pix_x) < H_A && ADDR_W'(pix_y) < V_A;
    assign pix_wr     = pix_grant && pix_in;
    assign pix_addr   = ADDR_W'(pix_y) * H_A + ADDR_W'(pix_x);
    assign fill_addr  = row_base_q + ADDR_W'(cur_x_q);
    assign last_beat  = cur_x_q == x1_q && cur_y_q == y1_q;
    assign cmd_ok     = fill_x0 <= fill_x1 && fill_y0 <= fill_y1 &&
                        ADDR_W'(fill_x1) < H_A && ADDR_W'(fill_y1) < V_A;

    assign fill_busy  = fill_req;
    assign fill_done  = fill_done_q;
    assign fill_error = fill_error_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

    // The pointer only moves when both requesters compete for the slot.
    always_comb begin
        state_d      = state_q;
        fav_fill_d   = (fill_req && pix_valid) ? !fav_fill_q : fav_fill_q;
        x0_d         = x0_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        color_d      = color_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        row_base_d   = row_base_q;
        mem_we_d     = fill_grant || pix_wr;
        mem_addr_d   = fill_grant ? fill_addr : pix_wr ? pix_addr : mem_addr_q;
        mem_data_d   = fill_grant ? color_q : pix_wr ? pix_color : mem_data_q;
        fill_done_d  = fill_grant && last_beat;
        fill_error_d = !fill_req && fill_start && !cmd_ok;
        if (!fill_req && fill_start && cmd_ok) begin
            state_d    = FILL;
            x0_d       = fill_x0;
            x1_d       = fill_x1;
            y1_d       = fill_y1;
            color_d    = fill_color;
            cur_x_d    = fill_x0;
            cur_y_d    = fill_y0;
            row_base_d = ADDR_W'(fill_y0) * H_A;
        end
        if (fill_grant) begin
            cur_x_d    = (cur_x_q == x1_q) ? x0_q : cur_x_q + 8'd1;
            cur_y_d    = (cur_x_q == x1_q) ? cur_y_q + 7'd1 : cur_y_q;
            row_base_d = (cur_x_q == x1_q) ? row_base_q + H_A : row_base_q;
            state_d    = last_beat ? IDLE : FILL;
        end
    end

    always_ff @(posedge clk_write or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fav_fill_q   <= 1'b0;
            x0_q         <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            color_q      <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            row_base_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            fill_done_q  <= 1'b0;
            fill_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fav_fill_q   <= fav_fill_d;
            x0_q         <= x0_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            color_q      <= color_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            row_base_q   <= row_base_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            fill_done_q  <= fill_done_d;
            fill_error_q <= fill_error_d;
        end
    end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: randomized and directed checks of fb_write_scheduler against
// a queue-based model of the fill scan and the alternating-grant rule.
module tb_fb_write_scheduler;
    logic        clk_write = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0, pix_ready;
    logic [7:0]  pix_x = '0;
    logic [6:0]  pix_y = '0;
    logic [2:0]  pix_color = '0;
    logic        fill_start = 1'b0;
    logic [7:0]  fill_x0 = '0, fill_x1 = '0;
    logic [6:0]  fill_y0 = '0, fill_y1 = '0;
    logic [2:0]  fill_color = '0;
    logic        fill_busy, fill_done, fill_error, mem_we;
    logic [15:0] mem_addr;
    logic [2:0]  mem_data;

    fb_write_scheduler dut (
        .clk_write(clk_write), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color), .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color), .fill_busy(fill_busy),
        .fill_done(fill_done), .fill_error(fill_error), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data)
    );

    always #5 clk_write = ~clk_write;

    int tests = 0, fails = 0;

    // Model: pending fill beats as a queue of addresses; the fill side wins a contended
    // slot exactly when the pixel side won the previous contended slot.
    int         q[$];
    bit         m_active, m_fill_next;
    logic [2:0] m_col;
    bit         e_we, e_done, e_err;
    int         e_addr;
    logic [2:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_fill_next = 0; m_col = '0;
        e_we = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step();
        bit was, pg, fg;
        int x0, x1, y0, y1, px, py;
        was = m_active;
        pg  = pix_valid && !(m_active && m_fill_next);
        fg  = m_active && !pg;
        if (m_active && pix_valid) m_fill_next = !m_fill_next;
        e_we = 0; e_done = 0; e_err = 0;
        px = int'(pix_x); py = int'(pix_y);
        if (pg && px < 160 && py < 120) begin
            e_we = 1; e_addr = py * 160 + px; e_data = pix_color;
        end
        if (fg) begin
            e_we = 1; e_addr = q.pop_front(); e_data = m_col;
            if (q.size() == 0) begin m_active = 0; e_done = 1; end
        end
        if (!was && fill_start) begin
            x0 = int'(fill_x0); x1 = int'(fill_x1); y0 = int'(fill_y0); y1 = int'(fill_y1);
            if (x0 <= x1 && y0 <= y1 && x1 < 160 && y1 < 120) begin
                for (int y = y0; y <= y1; y++)
                    for (int x = x0; x <= x1; x++) q.push_back(y * 160 + x);
                m_col = fill_color; m_active = 1;
            end else e_err = 1;
        end
    endtask

    // One clock: check pix_ready, advance model, then compare all registered outputs.
    task automatic step();
        #1;
        chk("pix_ready", pix_ready, !(m_active && m_fill_next));
        model_step();
        @(posedge clk_write); #1;
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data", mem_data, e_data);
        chk("fill_busy", fill_busy, m_active);
        chk("fill_done", fill_done, e_done);
        chk("fill_error", fill_error, e_err);
        fill_start = 0;
    endtask

    task automatic set_fill(input int x0, input int x1, input int y0, input int y1, input int c);
        fill_x0 = 8'(x0); fill_x1 = 8'(x1); fill_y0 = 7'(y0); fill_y1 = 7'(y1);
        fill_color = 3'(c); fill_start = 1;
    endtask

    initial begin
        int nw, fw, pw, dn, last, seq_bad, idx;
        model_reset();
        repeat (2) @(posedge clk_write);
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_error", fill_error, 0);
        reset = 0;

        pix_valid = 1; pix_x = 5; pix_y = 2; pix_color = 3;
        #1 chk("pix_ready_idle", pix_ready, 1);
        step();
        pix_valid = 0;
        chk("pix_we", mem_we, 1);
        chk("pix_addr", mem_addr, 325);
        chk("pix_data", mem_data, 3);
        step();
        chk("pix_we_after", mem_we, 0);

        pix_valid = 1; pix_x = 160; pix_y = 0; pix_color = 7;
        #1 chk("oor_ready", pix_ready, 1);
        step();
        pix_valid = 0;
        chk("oor_we", mem_we, 0);

        set_fill(20, 10, 0, 0, 1);
        step();
        chk("bad_err", fill_error, 1);
        chk("bad_busy", fill_busy, 0);
        chk("bad_we", mem_we, 0);
        step();
        chk("bad_err_clear", fill_error, 0);

        pix_valid = 1; pix_x = 0; pix_y = 0; pix_color = 1;
        set_fill(10, 13, 10, 10, 5);
        fw = 0; pw = 0; dn = 0;
        for (int i = 0; i < 12 && dn == 0; i++) begin
            step();
            if (mem_we && mem_data == 5 && mem_addr >= 1610 && mem_addr <= 1613) fw++;
            if (mem_we && mem_addr == 0 && mem_data == 1) pw++;
            if (fill_done) dn = i + 1;
        end
        pix_valid = 0;
        chk("mix_fill_writes", fw, 4);
        chk("mix_pix_writes", pw, 5);
        chk("mix_done_step", dn, 9);
        step();

        set_fill(0, 3, 0, 1, 2);
        step();
        nw = 0; dn = 0;
        for (int i = 0; i < 20 && dn == 0; i++) begin
            if (i == 1) set_fill(50, 60, 50, 60, 7);
            step();
            if (mem_we) nw++;
            if (fill_done) dn = 1;
        end
        chk("restart_done", dn, 1);
        chk("restart_writes", nw, 8);
        step();
        chk("restart_err", fill_error, 0);

        set_fill(0, 159, 0, 119, 0);
        step();
        nw = 0; dn = 0; last = -1; seq_bad = 0; idx = 0;
        for (int i = 0; i < 19300 && dn == 0; i++) begin
            step();
            if (mem_we) begin
                if (int'(mem_addr) != nw) seq_bad++;
                nw++; last = int'(mem_addr);
            end else if (nw > 0) seq_bad++;
            if (fill_done) begin dn = 1; idx = int'(mem_addr); end
        end
        chk("clear_writes", nw, 19200);
        chk("clear_last", last, 19199);
        chk("clear_done_addr", idx, 19199);
        chk("clear_seq", seq_bad, 0);
        step();
        chk("clear_busy_after", fill_busy, 0);

        set_fill(0, 159, 0, 10, 6);
        repeat (6) step();
        #3 reset = 1;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_data", mem_data, 0);
        chk("arst_busy", fill_busy, 0);
        chk("arst_done", fill_done, 0);
        model_reset();
        @(posedge clk_write); #1 reset = 0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin step(); if (fill_done) dn++; end
        chk("arst_no_done", dn, 0);
        set_fill(2, 4, 3, 3, 4);
        nw = 0; dn = 0;
        for (int i = 0; i < 8 && dn == 0; i++) begin
            step();
            if (mem_we) nw++;
            if (fill_done) dn = 1;
        end
        chk("post_rst_done", dn, 1);
        chk("post_rst_writes", nw, 3);

        for (int i = 0; i < 3000; i++) begin
            int x0, y0;
            pix_valid = 1'($urandom_range(0, 1));
            pix_x = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
            pix_y = 7'($urandom_range(0, 127));
            pix_color = 3'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                x0 = $urandom_range(1, 165); y0 = $urandom_range(0, 122);
                if ($urandom_range(0, 7) == 0) set_fill(x0, x0 - 1, y0, y0 + 2, $urandom_range(0, 7));
                else set_fill(x0, x0 + $urandom_range(0, 4), y0, y0 + $urandom_range(0, 2), $urandom_range(0, 7));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
